// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core opcodes, bubble word and fetch state encoding
// Purpose: constants shared by fetch and decode.
//   Opcodes are 7-bit values taken from instr[15:9].
//   NOP_WORD is the bubble instruction.
//   Fetch states use 3-bit localparam encodings.
package core_pkg;

  localparam logic [6:0] OP_IADD = 7'b0100000;
  localparam logic [6:0] OP_LDM  = 7'b0110101;
  localparam logic [6:0] OP_LDD  = 7'b0100010;
  localparam logic [6:0] OP_STD  = 7'b0100011;
  localparam logic [6:0] OP_HLT  = 7'b1100001;
  localparam logic [6:0] OP_NOP  = 7'b1101000;

  localparam logic [15:0] NOP_WORD = {OP_NOP, 9'd0};

  localparam logic [2:0] VEC_HI    = 3'd0;
  localparam logic [2:0] VEC_LO    = 3'd1;
  localparam logic [2:0] FETCH     = 3'd2;
  localparam logic [2:0] FETCH_IMM = 3'd3;
  localparam logic [2:0] HALT      = 3'd4;

endpackage

// File: rtl/fetch_opclass.sv
// rtl/fetch_opclass.sv - opcode classifier for immediate and halt instructions
// Purpose: classifies an opcode. Decode also uses it for its operand-count checks.
// Ports:
//   opcode  in  7  instr[15:9]
//   has_imm out 1  the instruction is followed by an immediate word
//   is_hlt  out 1  the opcode is HLT
module fetch_opclass
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       has_imm,
  output logic       is_hlt
);

  always_comb begin
    has_imm = (opcode == OP_IADD) || (opcode == OP_LDM) ||
              (opcode == OP_LDD)  || (opcode == OP_STD);
    is_hlt  = (opcode == OP_HLT);
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with reset vector, two-word assembly and IF/ID register
// Purpose: owns the PC and loads the reset vector from words 0 and 1.
//   Fetches 16-bit instructions and joins two-word immediate forms.
//   Drives the IF/ID register. Handles stall, branch redirect and halt.
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   imem_addr/imem_data instruction memory; read data is combinational
//   stall               holds the whole stage
//   branch_taken/target redirect request from execute
//   if_valid/if_instr   IF/ID register contents
//   if_imm/if_pc        IF/ID register contents
//   halted              HLT was fetched; fetch is frozen until reset
module fetch_unit
  import core_pkg::*;
#(
  parameter int          ADDR_W   = 20,
  parameter logic [15:0] NOP_WORD = core_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              if_valid,
  output logic [15:0]       if_instr,
  output logic [15:0]       if_imm,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-17:0] vec_hi;  // only the bits that reach the PC are kept
  logic [15:0]       hold;     // first word of a two-word instruction
  logic              has_imm;
  logic              is_hlt;

  assign pc_inc = pc + ADDR_W'(1);

  fetch_opclass u_opclass (
    .opcode  (imem_data[15:9]),
    .has_imm (has_imm),
    .is_hlt  (is_hlt)
  );

  always_comb begin
    case (state)
      VEC_HI:  imem_addr = '0;
      VEC_LO:  imem_addr = ADDR_W'(1);
      default: imem_addr = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= VEC_HI;
      pc       <= '0;
      vec_hi   <= '0;
      hold     <= '0;
      if_valid <= 1'b0;
      if_instr <= NOP_WORD;
      if_imm   <= '0;
      if_pc    <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        // The vector load ignores stall and branch so that it always completes.
        VEC_HI: begin
          vec_hi   <= imem_data[ADDR_W-17:0];
          state    <= VEC_LO;
          if_valid <= 1'b0;
          if_instr <= NOP_WORD;
          if_imm   <= '0;
        end
        VEC_LO: begin
          pc       <= {vec_hi, imem_data};
          state    <= FETCH;
          if_valid <= 1'b0;
          if_instr <= NOP_WORD;
          if_imm   <= '0;
        end
        HALT: begin
          if_valid <= 1'b0;
          if_instr <= NOP_WORD;
          if_imm   <= '0;
          halted   <= 1'b1;
        end
        default: begin
          if (branch_taken) begin
            // A half-assembled two-word instruction is dropped here.
            pc       <= branch_target;
            state    <= FETCH;
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
            if_imm   <= '0;
          end else if (!stall) begin
            pc <= pc_inc;
            if (state == FETCH_IMM) begin
              state    <= FETCH;
              if_valid <= 1'b1;
              if_instr <= hold;
              if_imm   <= imem_data;
              if_pc    <= pc_inc;
            end else if (has_imm) begin
              hold     <= imem_data;
              state    <= FETCH_IMM;
              if_valid <= 1'b0;
              if_instr <= NOP_WORD;
              if_imm   <= '0;
            end else begin
              if_valid <= 1'b1;
              if_instr <= imem_data;
              if_imm   <= '0;
              if_pc    <= pc_inc;
              if (is_hlt) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                state  <= FETCH;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, directed sequences, random vs model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [19:0] branch_target = '0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_imm;
  logic [19:0] if_pc;
  logic        halted;

  fetch_unit #(.ADDR_W(20)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_imm        (if_imm),
    .if_pc         (if_pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // 256-word memory; higher address bits fold into the index so every address maps somewhere.
  logic [15:0] mem [256];
  function automatic logic [7:0] idx(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]};
  endfunction
  always_comb imem_data = mem[idx(imem_addr)];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_vec;      // vector words still to load (2, 1 or 0)
  bit          m_known = 0;
  logic [3:0]  m_hi;
  logic [19:0] m_pc;
  bit          m_pend;     // first word of a two-word instruction is waiting
  logic [15:0] m_first;
  bit          m_halt;
  logic        e_valid, e_halt;
  logic [15:0] e_instr, e_imm;
  logic [19:0] e_pc;
  bit          e_pcchk;

  function automatic logic [19:0] m_addr();
    return (m_vec == 2) ? 20'h0 : (m_vec == 1) ? 20'h1 : m_pc;
  endfunction

  task automatic bubble();
    e_valid = 0; e_instr = 16'hD000; e_imm = 0; e_pcchk = 0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic b, input logic [19:0] t);
    logic [15:0] w;
    if (!r) begin
      m_known = 1; m_vec = 2; m_pc = 0; m_pend = 0; m_halt = 0;
      bubble(); e_pc = 0; e_pcchk = 1; e_halt = 0;
    end else if (!m_known) begin
      // nothing to predict before the first reset
    end else if (m_vec == 2) begin
      m_hi = mem[idx(20'h0)][3:0]; m_vec = 1; bubble();
    end else if (m_vec == 1) begin
      m_pc = {m_hi, mem[idx(20'h1)]}; m_vec = 0; bubble();
    end else if (m_halt) begin
      bubble(); e_halt = 1;
    end else if (b) begin
      m_pc = t; m_pend = 0; bubble();
    end else if (!s) begin
      w = mem[idx(m_pc)];
      if (m_pend) begin
        e_valid = 1; e_instr = m_first; e_imm = w; e_pc = m_pc + 1; e_pcchk = 1;
        m_pend = 0;
      end else if (w[15:9] inside {7'h20, 7'h35, 7'h22, 7'h23}) begin
        m_first = w; m_pend = 1; bubble();
      end else begin
        e_valid = 1; e_instr = w; e_imm = 0; e_pc = m_pc + 1; e_pcchk = 1;
        if (w[15:9] == 7'h61) begin m_halt = 1; e_halt = 1; end
      end
      m_pc = m_pc + 1;
    end
  endtask

  // Called at a negedge: drive, check the address, clock once, check the IF/ID outputs.
  task automatic step(input logic r, input logic s, input logic b, input logic [19:0] t);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    #1;
    if (m_known) chk("imem_addr", imem_addr, m_addr());
    model_step(r, s, b, t);
    @(posedge clk); #1;
    if (m_known) begin
      chk("if_valid", if_valid, e_valid);
      chk("if_instr", if_instr, e_instr);
      chk("if_imm", if_imm, e_imm);
      chk("halted", halted, e_halt);
      if (e_pcchk) chk("if_pc", if_pc, e_pc);
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] rnd_word();
    int r = $urandom_range(0, 19);
    logic [15:0] w = 16'($urandom);
    if (r == 0) w[15:9] = 7'h61;
    else if (r < 5) begin
      case ($urandom_range(0, 3))
        0: w[15:9] = 7'h20;
        1: w[15:9] = 7'h35;
        2: w[15:9] = 7'h22;
        default: w[15:9] = 7'h23;
      endcase
    end else if (w[15:9] == 7'h61) w[15:9] = 7'h01;
    return w;
  endfunction

  // ---------------- table of hand-derived vectors ----------------
  typedef struct {
    logic r, s, b; logic [19:0] t;
    logic ac; logic [19:0] addr;
    logic v; logic [15:0] instr, imm;
    logic pc_chk; logic [19:0] pc;
    logic h;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t row(input logic r, s, b, input logic [19:0] t, input logic ac,
                               input logic [19:0] addr, input logic v, input logic [15:0] instr,
                               input logic [15:0] imm, input logic pc_chk, input logic [19:0] pc,
                               input logic h);
    vec_t x;
    x.r = r; x.s = s; x.b = b; x.t = t; x.ac = ac; x.addr = addr; x.v = v;
    x.instr = instr; x.imm = imm; x.pc_chk = pc_chk; x.pc = pc; x.h = h;
    return x;
  endfunction

  initial begin
    //               r  s  b  tgt    ac addr    v  instr     imm       pc? pc     h
    tbl[0]  = row(0, 0, 0, 20'h0,  0, 20'h0,  0, 16'hD000, 16'h0,    1, 20'h0,  0);
    tbl[1]  = row(0, 0, 1, 20'h40, 1, 20'h0,  0, 16'hD000, 16'h0,    1, 20'h0,  0);
    tbl[2]  = row(1, 1, 0, 20'h0,  1, 20'h0,  0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[3]  = row(1, 1, 0, 20'h0,  1, 20'h1,  0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[4]  = row(1, 0, 0, 20'h0,  1, 20'h10, 0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[5]  = row(1, 1, 0, 20'h0,  1, 20'h11, 0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[6]  = row(1, 1, 0, 20'h0,  1, 20'h11, 0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[7]  = row(1, 1, 0, 20'h0,  1, 20'h11, 0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[8]  = row(1, 0, 0, 20'h0,  1, 20'h11, 1, 16'h4000, 16'h1234, 1, 20'h12, 0);
    tbl[9]  = row(1, 0, 0, 20'h0,  1, 20'h12, 1, 16'h2200, 16'h0,    1, 20'h13, 0);
    tbl[10] = row(1, 0, 0, 20'h0,  1, 20'h13, 0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[11] = row(1, 1, 1, 20'h40, 1, 20'h14, 0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[12] = row(1, 0, 0, 20'h0,  1, 20'h40, 1, 16'h0200, 16'h0,    1, 20'h41, 0);
    tbl[13] = row(1, 0, 0, 20'h0,  1, 20'h41, 1, 16'hC200, 16'h0,    1, 20'h42, 1);
    tbl[14] = row(1, 0, 1, 20'h10, 1, 20'h42, 0, 16'hD000, 16'h0,    0, 20'h0,  1);
    tbl[15] = row(1, 1, 0, 20'h0,  1, 20'h42, 0, 16'hD000, 16'h0,    0, 20'h0,  1);
    tbl[16] = row(0, 0, 0, 20'h0,  1, 20'h42, 0, 16'hD000, 16'h0,    1, 20'h0,  0);
    tbl[17] = row(1, 0, 0, 20'h0,  1, 20'h0,  0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[18] = row(1, 0, 0, 20'h0,  1, 20'h1,  0, 16'hD000, 16'h0,    0, 20'h0,  0);
    tbl[19] = row(1, 0, 0, 20'h0,  1, 20'h10, 0, 16'hD000, 16'h0,    0, 20'h0,  0);

    foreach (mem[i]) mem[i] = 16'h0200;
    mem[0] = 16'h0000; mem[1] = 16'h0010;
    mem[8'h10] = 16'h4000; mem[8'h11] = 16'h1234; mem[8'h12] = 16'h2200;
    mem[8'h13] = 16'h4600; mem[8'h40] = 16'h0200; mem[8'h41] = 16'hC200;

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].r; stall = tbl[i].s; branch_taken = tbl[i].b; branch_target = tbl[i].t;
      #1;
      if (tbl[i].ac) chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
      @(posedge clk); #1;
      chk($sformatf("row%0d if_valid", i), if_valid, tbl[i].v);
      chk($sformatf("row%0d if_instr", i), if_instr, tbl[i].instr);
      chk($sformatf("row%0d if_imm", i), if_imm, tbl[i].imm);
      chk($sformatf("row%0d halted", i), halted, tbl[i].h);
      if (tbl[i].pc_chk) chk($sformatf("row%0d if_pc", i), if_pc, tbl[i].pc);
      @(negedge clk);
    end

    // Single-word stream from the reset vector.
    mem[0] = 16'h0000; mem[1] = 16'h0010; mem[8'h10] = 16'h2200; mem[8'h11] = 16'h0200;
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("stream1 instr", if_instr, 16'h2200); chk("stream1 pc", if_pc, 20'h11);
    step(1, 0, 0, 0);
    chk("stream2 instr", if_instr, 16'h0200); chk("stream2 pc", if_pc, 20'h12);

    // PC wrap: vector 0xFFFFF, the instruction there reports if_pc 0.
    mem[0] = 16'h000F; mem[1] = 16'hFFFF; mem[idx(20'hFFFFF)] = 16'h0200;
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("wrap valid", if_valid, 1'b1); chk("wrap pc", if_pc, 20'h0);
    step(1, 0, 0, 0);

    // Randomized traffic against the model.
    for (int round = 0; round < 4; round++) begin
      foreach (mem[i]) mem[i] = rnd_word();
      mem[0] = 16'($urandom); mem[1] = 16'($urandom);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      for (int c = 0; c < 600; c++)
        step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 3) == 0),
             logic'($urandom_range(0, 11) == 0), 20'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the core. Owns the PC and loads the reset vector from instruction memory. Fetches 16-bit instruction words and assembles two-word immediate instructions. Drives the IF/ID register whose opcode field feeds the control unit in decode; honours stall, branch redirect and halt.

Parameters:
ADDR_W, 20, instruction-memory word-address / PC width (legal range 17..32)
NOP_WORD, 16'hD000, bubble instruction (NOP opcode 7'b1101000 in [15:9], zeros below)

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-low reset
imem_addr  out  ADDR_W  instruction-memory word address (combinational from state/PC)
imem_data  in  16  instruction-memory read data, combinational same cycle
stall  in  1  hazard stall from decode; hold stage
branch_taken  in  1  redirect request from execute
branch_target  in  ADDR_W  redirect address
if_valid  out  1  IF/ID holds a real instruction
if_instr  out  16  instruction word; opcode = if_instr[15:9]
if_imm  out  16  immediate word (two-word instructions only, else 0)
if_pc  out  ADDR_W  address following the last word of this instruction
halted  out  1  HLT fetched; fetch frozen

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=VEC_HI; pc=0.
  - if_valid=0, if_instr=NOP_WORD, if_imm=0, if_pc=0, halted=0.
  - Reset overrides every other input, including mid two-word fetch.
- imem_addr by state:
  - VEC_HI: 0
  - VEC_LO: 1
  - all other states: pc
- States:
  - VEC_HI: latch vec_hi=imem_data -> VEC_LO. Outputs hold the bubble.
  - VEC_LO: pc <= {vec_hi[ADDR_W-17:0], imem_data} -> FETCH. Outputs hold the bubble.
  - FETCH, single-word opcode:
    - if_valid=1, if_instr=imem_data, if_imm=0, if_pc=pc+1.
    - pc<=pc+1.
  - FETCH, opcode in {IADD 0100000, LDM 0110101, LDD 0100010, STD 0100011}:
    - latch imemory word into hold reg; pc<=pc+1 -> FETCH_IMM.
    - Emit bubble (if_valid=0, if_instr=NOP_WORD, if_imm=0).
  - FETCH, opcode HLT 1100001:
    - Emit valid HLT; pc<=pc+1 -> HALT.
    - halted=1 from the next cycle.
  - FETCH_IMM:
    - if_valid=1, if_instr=hold reg, if_imm=imem_data, if_pc=pc+1.
    - pc<=pc+1 -> FETCH.
  - HALT:
    - Emit bubble every cycle; pc frozen; halted=1.
    - branch_taken and stall are ignored; only reset exits.
- Priority, highest first (outside VEC_* and HALT): reset > branch_taken > stall > normal.
- branch_taken=1:
  - pc<=branch_target; emit bubble; state->FETCH.
  - Any half-assembled two-word instruction is discarded; the hold reg is don't-care.
- stall=1 (no branch):
  - All registers hold: pc, state, hold reg, every if_* output.
  - imem_addr keeps presenting the same address.
  - stall in VEC_* states is ignored; vector load always completes.
- PC arithmetic is modulo 2^ADDR_W; pc+1 at all-ones wraps to 0 with no flag.
- Latency: a single-word instruction at address A appears on if_* one edge after pc==A in FETCH. A two-word instruction appears two edges after.

Decomposition:
- Shared package core_pkg holds:
  - opcode localparams: OP_IADD, OP_LDM, OP_LDD, OP_STD, OP_HLT, OP_NOP.
  - NOP_WORD.
  - fetch state encoding: VEC_HI, VEC_LO, FETCH, FETCH_IMM, HALT.
- One natural sub-module: fetch_opclass, combinational.
  - Input: opcode[6:0].
  - Outputs: has_imm, is_hlt.
  - Reused by decode for operand-count checks.

Test Plan:
- Reset vector: M[0]=0x0000, M[1]=0x0010, reset low 2 cycles then high -> imem_addr 0,1,then 0x00010; first valid instruction is M[0x10], with if_pc=0x00011.
- Single-word stream: M[0x10]=NOT (0x2200), M[0x11]=ADD (0x0200) -> if_valid=1 on consecutive cycles, if_instr 0x2200 then 0x0200, if_pc 0x11 then 0x12.
- Two-word IADD: M[0x10]=0x4000, M[0x11]=0x1234 -> one bubble cycle, then if_valid=1, if_instr=0x4000, if_imm=0x1234, if_pc=0x12.
- Stall inside FETCH_IMM: assert stall 3 cycles after the IADD first word -> pc stays 0x11 and outputs hold the bubble. On release, IADD is emitted with imm 0x1234, exactly once.
- Branch in FETCH_IMM: branch_taken=1, target 0x40 while in FETCH_IMM -> bubble, no IADD emitted, next valid is M[0x40]. Also assert stall together with branch_taken -> branch wins.
- HLT and reset recovery: M[0x10]=0xC200 -> valid HLT emitted, halted=1, then bubbles forever despite branch_taken. Assert reset low mid-HALT -> halted=0 and vector reload from address 0.
